mop_load_sched: RTL and testbench

Round-robin scheduler that shares one instruction-store write port (`ext_wr`/`ext_data_in`/`ext_addr`) between `N_REQ` initiators. Each initiator requests a program load of `WORDS` instruction words. The scheduler grants one initiator at a time, sequences its words into consecutive store addresses, and signals completion or abort. It sits between the per-initiator MOP/redirect logic and the instruction store, and replaces the per-initiator `load_ctrl` bit-select loaders.

---
 rtl/mop_load_sched_if.sv | 31 +++
 rtl/mop_load_sched.sv | 137 +++++++++++++
 tb/tb_mop_load_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mop_load_sched_if.sv
// Initiator request/data lanes and instruction-store write port of the load scheduler.
// The master side is the initiator/store fabric; the slave side is the scheduler itself.
interface mop_load_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 17,
  parameter int ADDR_W = 3
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        data_valid_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        grant_o;
  logic                    ext_wr_o;
  logic [DATA_W-1:0]       ext_data_o;
  logic [ADDR_W-1:0]       ext_addr_o;
  logic [ID_W-1:0]         ext_id_o;
  logic                    done_o;
  logic                    abort_o;
  logic                    busy_o;

  modport master (
    output req_i, data_valid_i, data_i,
    input  grant_o, ext_wr_o, ext_data_o, ext_addr_o, ext_id_o, done_o, abort_o, busy_o
  );

  modport slave (
    input  req_i, data_valid_i, data_i,
    output grant_o, ext_wr_o, ext_data_o, ext_addr_o, ext_id_o, done_o, abort_o, busy_o
  );
endinterface

// File: rtl/mop_load_sched.sv
// Round-robin scheduler sharing one instruction-store write port between N_REQ program loaders.
// Grant and all store-side outputs are registered; the grant doubles as ready for the owner.
module mop_load_sched #(
  parameter int N_REQ  = 4,
  parameter int WORDS  = 8,
  parameter int DATA_W = 17,
  parameter int ADDR_W = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  mop_load_sched_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   next_ptr;
  logic [DATA_W-1:0] beat_data;
  logic              owner_req;
  logic              beat_ok;
  logic              found;

  // First requester at or above ptr, wrapping; ptr itself is only moved on completion/abort.
  always_comb begin : arbiter
    int idx;
    idx   = 0;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign owner_req = bus.req_i[id_q];
  assign beat_ok   = grant_q[id_q] & owner_req & bus.data_valid_i[id_q];
  assign beat_data = bus.data_i[int'(id_q)*DATA_W +: DATA_W];
  assign next_ptr  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = pick;
          grant_d = N_REQ'(1) << pick;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // A dropped request wins over a coincident beat, so nothing is written.
        if (!owner_req) begin
          abort_d = 1'b1;
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else if (beat_ok) begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          data_d = beat_data;
          if (cnt_q == ADDR_W'(WORDS - 1)) begin
            done_d  = 1'b1;
            grant_d = '0;
            ptr_d   = next_ptr;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.ext_wr_o   = wr_q;
  assign bus.ext_data_o = data_q;
  assign bus.ext_addr_o = addr_q;
  assign bus.ext_id_o   = id_q;
  assign bus.done_o     = done_q;
  assign bus.abort_o    = abort_q;
  assign bus.busy_o     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mop_load_sched.sv
// Randomized bench for mop_load_sched: transaction-level reference model feeds expected
// writes, grants and completion events into queues that a negedge monitor drains.
module tb_mop_load_sched;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = 17;
  localparam int AW = 3;

  typedef struct { int id; int addr; int data; } wr_t;
  typedef struct { bit abrt; int id; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mop_load_sched_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  mop_load_sched #(.N_REQ(N), .WORDS(W), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference model: who owns the port, how many words it has delivered, whose turn is next.
  int  m_owner = -1;
  int  m_beats = 0;
  int  m_ptr   = 0;
  int  m_gap   = 0;
  int  n_evt   = 0;
  int  cyc     = 0;
  bit  want[N];
  bit  once[N];
  bit  alt[N];
  int  p_start[N];
  int  p_valid[N];
  int  drop_at[N];
  int  p_drop = 0;
  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  exp_gnt[$];

  task automatic reset_agents();
    for (int k = 0; k < N; k++) begin
      once[k] = 1'b0; alt[k] = 1'b0; p_start[k] = 0; p_valid[k] = 100; drop_at[k] = -1;
    end
    p_drop = 0;
  endtask

  task automatic finish_owner(bit ab);
    exp_ev.push_back('{ab, m_owner});
    want[m_owner] = 1'b0;
    if (once[m_owner]) p_start[m_owner] = 0;
    m_ptr   = (m_owner + 1) % N;
    m_gap   = ab ? 0 : 1;   // a completed program spends one cycle announcing done
    m_owner = -1;
    n_evt++;
  endtask

  task automatic model(logic [N-1:0] rq, logic [N-1:0] dv, logic [N*DW-1:0] dt);
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_gap = 0;
      return;
    end
    if (m_owner >= 0) begin
      if (!rq[m_owner]) finish_owner(1'b1);
      else if (dv[m_owner]) begin
        exp_wr.push_back('{m_owner, m_beats, int'(dt[m_owner*DW +: DW])});
        m_beats++;
        if (m_beats == W) finish_owner(1'b0);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (rq != '0) begin
      for (int i = 0; i < N; i++)
        if (m_owner < 0 && rq[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      m_beats = 0;
      exp_gnt.push_back(m_owner);
    end
  endtask

  task automatic step(bit r);
    logic [N-1:0]    rq;
    logic [N-1:0]    dv;
    logic [N*DW-1:0] dt;
    bit              drop;
    @(negedge clk);
    #1;
    cyc++;
    rst = r;
    rq = '0; dv = '0; dt = '0;
    for (int k = 0; k < N; k++) begin
      if (r) want[k] = 1'b0;
      else if (!want[k] && $urandom_range(99) < p_start[k]) want[k] = 1'b1;
      drop = want[k] && m_owner == k && m_beats == drop_at[k];
      if (drop) begin
        want[k] = 1'b0;
        drop_at[k] = -1;
      end else if (want[k] && m_owner == k && $urandom_range(999) < p_drop) begin
        want[k] = 1'b0;
      end
      rq[k] = want[k];
      dv[k] = drop | (alt[k] ? cyc[0] : ($urandom_range(99) < p_valid[k]));
      dt[k*DW +: DW] = DW'($urandom);
    end
    bus.req_i        = rq;
    bus.data_valid_i = dv;
    bus.data_i       = dt;
    model(rq, dv, dt);
  endtask

  task automatic run_evt(int n, int budget);
    int tgt;
    tgt = n_evt + n;
    for (int i = 0; i < budget && n_evt < tgt; i++) step(1'b0);
    if (n_evt < tgt) begin
      n_cmp++; n_bad++;
      $display("FAIL run_evt: reached %0d events, required %0d", n_evt, tgt);
    end
  endtask

  task automatic quiesce();
    int i;
    for (int k = 0; k < N; k++) begin
      p_start[k] = 0;
      if (k != m_owner) want[k] = 1'b0;
    end
    p_drop = 0;
    i = 0;
    while (i < 60 && (m_owner >= 0 || m_gap > 0 || exp_wr.size() != 0 ||
                      exp_ev.size() != 0 || exp_gnt.size() != 0)) begin
      step(1'b0);
      i++;
    end
    if (i == 60) begin
      n_cmp++; n_bad++;
      $display("FAIL quiesce: pending wr=%0d ev=%0d gnt=%0d, required all 0",
               exp_wr.size(), exp_ev.size(), exp_gnt.size());
    end
    step(1'b0);
    step(1'b0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_grant"}, int'(bus.grant_o), 0);
    check({tag, "_wr"},    int'(bus.ext_wr_o), 0);
    check({tag, "_data"},  int'(bus.ext_data_o), 0);
    check({tag, "_addr"},  int'(bus.ext_addr_o), 0);
    check({tag, "_id"},    int'(bus.ext_id_o), 0);
    check({tag, "_done"},  int'(bus.done_o), 0);
    check({tag, "_abort"}, int'(bus.abort_o), 0);
    check({tag, "_busy"},  int'(bus.busy_o), 0);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write, grant or event.
  logic [N-1:0] prev_gnt = '0;
  wr_t mw;
  ev_t me;
  int  mg;
  always @(negedge clk) begin
    if (bus.ext_wr_o) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h, required no write",
                 bus.ext_addr_o, bus.ext_data_o);
      end else begin
        mw = exp_wr.pop_front();
        check("wr_id",   int'(bus.ext_id_o),   mw.id);
        check("wr_addr", int'(bus.ext_addr_o), mw.addr);
        check("wr_data", int'(bus.ext_data_o), mw.data);
      end
    end
    if (bus.done_o || bus.abort_o) begin
      check("done_abort_excl", int'(bus.done_o & bus.abort_o), 0);
      if (exp_ev.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: done %0d abort %0d, required none", bus.done_o, bus.abort_o);
      end else begin
        me = exp_ev.pop_front();
        check("evt_abort", int'(bus.abort_o), int'(me.abrt));
        check("evt_id",    int'(bus.ext_id_o), me.id);
      end
    end
    if (bus.grant_o != '0 && prev_gnt == '0) begin
      if (exp_gnt.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_grant: got %0h, required none", bus.grant_o);
      end else begin
        mg = exp_gnt.pop_front();
        check("grant_vec", int'(bus.grant_o), 1 << mg);
        check("grant_id",  int'(bus.ext_id_o), mg);
      end
    end
    check("busy", int'(bus.busy_o), int'((bus.grant_o != '0) | bus.done_o));
    prev_gnt = bus.grant_o;
  end

  initial begin
    int i;
    bus.req_i = '0;
    bus.data_valid_i = '0;
    bus.data_i = '0;
    for (int k = 0; k < N; k++) want[k] = 1'b0;
    reset_agents();
    repeat (3) step(1'b1);
    @(posedge clk); #1;
    check_zero("reset");

    // Single full load by initiator 0.
    p_start[0] = 100; once[0] = 1'b1;
    run_evt(1, 40);
    quiesce();

    // Fairness with 0, 1, 3 held from ptr=0.
    step(1'b1);
    reset_agents();
    p_start[0] = 100; p_start[1] = 100; p_start[3] = 100;
    run_evt(4, 80);
    quiesce();

    // Alternate-cycle valid on initiator 2.
    reset_agents();
    alt[2] = 1'b1; p_start[2] = 100; once[2] = 1'b1;
    run_evt(1, 60);
    quiesce();

    // Abort after 3 beats, then 0 and 2 compete (2 must win).
    reset_agents();
    p_start[1] = 100; once[1] = 1'b1; drop_at[1] = 3;
    run_evt(1, 40);
    p_start[0] = 100; once[0] = 1'b1; p_start[2] = 100; once[2] = 1'b1;
    run_evt(2, 80);
    quiesce();

    // Reset after 5 beats, then 1 and 2 compete from ptr=0.
    reset_agents();
    p_start[0] = 100; once[0] = 1'b1;
    i = 0;
    while (i < 40 && !(m_owner == 0 && m_beats == 5)) begin
      step(1'b0);
      i++;
    end
    if (i == 40) begin
      n_cmp++; n_bad++;
      $display("FAIL midrst_wait: beats %0d, required 5", m_beats);
    end
    step(1'b1);
    @(posedge clk); #1;
    check_zero("midrst");
    reset_agents();
    p_start[1] = 100; once[1] = 1'b1; p_start[2] = 100; once[2] = 1'b1;
    run_evt(2, 80);
    quiesce();

    // Pointer wrap: serve 3, then 0 and 3 compete.
    reset_agents();
    p_start[3] = 100; once[3] = 1'b1;
    run_evt(1, 40);
    p_start[0] = 100; once[0] = 1'b1; p_start[3] = 100; once[3] = 1'b1;
    run_evt(2, 80);
    quiesce();

    // Random traffic with sporadic abandons.
    reset_agents();
    for (int k = 0; k < N; k++) begin
      p_start[k] = 30; p_valid[k] = 70;
    end
    p_drop = 8;
    repeat (1500) step(1'b0);
    quiesce();

    check("left_wr",  exp_wr.size(),  0);
    check("left_ev",  exp_ev.size(),  0);
    check("left_gnt", exp_gnt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
